control_unit: RTL and testbench
===============================

# control_unit

Hardwired control sequencer for the datapath. It drives every strobe that the datapath bench currently sequences by hand: PC_out, MAR_enable, Read, MDR_enable/MDR_out, IR_enable, Y_enable, Z_enable, ZLow_out/ZHigh_out, the ALU opcode and the per-register out/enable lines. It runs fetch (T0–T2), then decodes IR and runs the execute steps for register ALU, unary, multiply/divide, nop and halt instructions. It sits directly upstream of the datapath and reads back only IR and a memory-ready flag.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge.
- clr  in  1  asynchronous, active-low reset.
- IR  in  32  instruction register contents from the datapath.
  - opcode = IR[31:27]
  - Ra = IR[26:23]
  - Rb = IR[22:19]
  - Rc = IR[18:15]
- mem_ready  in  1  memory read data valid on Mdatain this cycle.
- PC_out, IncPC, PC_enable, MAR_enable  out  1 each  fetch strobes.
- Read, MDR_enable, MDR_out, IR_enable  out  1 each  memory/IR strobes.
- Y_enable, Z_enable, ZLow_out, ZHigh_out, HI_enable, LO_enable  out  1 each  ALU path strobes.
- opcode  out  5  ALU operation select. Equals IR[31:27] in the ALU step, 0 otherwise.
- R_out  out  16  one-hot register bus-drive select (bit n = Rn_out).
- R_enable  out  16  one-hot register load select (bit n = Rn_enable).
- run  out  1  high unless halted.
- illegal  out  1  sticky: an undefined opcode was executed.

## Operation
- States:
  - RST: after reset.
  - T0, T1, T2: fetch.
  - T3–T6: execute.
  - HALT.
- Outputs are Moore: decoded from the state register and IR only. The state register and illegal are the only flops.
- RST: all outputs 0, except run=1. Goes to T0 on the first clock edge after clr deasserts.
- T0: PC_out, MAR_enable, IncPC, PC_enable.
- T1: Read, MDR_enable. Holds in T1 while mem_ready=0. Leaves to T2 on the edge where mem_ready=1.
- T2: MDR_out, IR_enable. IR is valid from T3 onward.
- T3 decodes the opcode class:
  - Binary ALU (add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011):
    - T3: R_out[Rb], Y_enable.
    - T4: R_out[Rc], opcode, Z_enable.
    - T5: ZLow_out, R_enable[Ra].
    - Then T0.
  - mul 01111, div 10000:
    - T3: R_out[Ra], Y_enable.
    - T4: R_out[Rb], opcode, Z_enable.
    - T5: ZLow_out, LO_enable.
    - T6: ZHigh_out, HI_enable.
    - Then T0.
  - neg 10001, not 10010:
    - T3: R_out[Rb], opcode, Z_enable.
    - T4: ZLow_out, R_enable[Ra].
    - Then T0.
  - nop 11010: T3 has no strobes, then T0.
  - halt 11011: T3 has no strobes, then HALT.
  - Any other opcode: behaves as nop and sets illegal. illegal clears only on reset.
- HALT: all strobes 0, run=0. Left only by reset.
- At most one bit of R_out is high in any cycle; likewise for R_enable. Both are 0 outside the steps listed above.
- Register index 0 decodes to bit 0 like any other register; there is no special-casing of R0.

## Timing
- Cycles per instruction, counting T0 to the next T0, with zero memory wait:
  - binary ALU: 6
  - unary: 5
  - mul/div: 7
  - nop/illegal: 4
  - halt: 4 cycles to reach HALT.
- Each T1 wait cycle adds one cycle. mem_ready is sampled only in T1 and ignored elsewhere.
- clr low at any time, mid-instruction included: state goes to RST and outputs go to their reset values immediately, without waiting for a clock. illegal clears.
- IR changing outside T2 has no effect on the fetch states. During T3–T6, outputs follow the current IR combinationally. The datapath only loads IR in T2.

## Structure
- Package cpu_ctrl_pkg holds:
  - opcode constants listed above;
  - state enum (RST, T0–T6, HALT);
  - IR field bit positions.
  The datapath's ALU imports the same opcode constants.
- Sub-module reg_decoder: 4-bit index plus enable in, 16-bit one-hot out. Instantiated twice, once for R_out and once for R_enable.

## Test plan
- Reset, then IR=32'h28918000 (and R1,R2,R3), mem_ready=1:
  - state sequence T0,T1,T2,T3,T4,T5,T0;
  - T3: R_out=16'h0004 and Y_enable;
  - T4: R_out=16'h0008, opcode=5'b00101, Z_enable;
  - T5: ZLow_out, R_enable=16'h0002.
- mem_ready held 0 for 3 cycles in T1: Read and MDR_enable stay high for 4 cycles; T2 follows on the first edge with mem_ready=1.
- mul R4,R5 (IR opcode 01111, Ra=4, Rb=5):
  - T3: R_out=16'h0010;
  - T4: R_out=16'h0020;
  - T5: LO_enable with ZLow_out;
  - T6: HI_enable with ZHigh_out;
  - 7 cycles total.
- halt (IR[31:27]=11011): enters HALT after T3 with run=0. It stays there for 20 cycles with all strobes 0.
- Opcode 11111 → illegal=1 after T3, then T0 follows. Pulling clr low mid-T4 of the next instruction forces all outputs 0, illegal=0 and RST immediately.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode constants, IR field positions and sequencer state types.
// The datapath ALU imports the same opcode constants.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam int IR_OP_LSB = 27;
    localparam int IR_RA_LSB = 23;
    localparam int IR_RB_LSB = 19;
    localparam int IR_RC_LSB = 15;

    typedef enum logic [3:0] {
        ST_RST, ST_T0, ST_T1, ST_T2, ST_T3,
        ST_T4, ST_T5, ST_T6, ST_HALT
    } state_e;

    typedef enum logic [2:0] {
        CL_ALU, CL_MULDIV, CL_UNARY,
        CL_NOP, CL_HALT, CL_ILLEGAL
    } op_class_e;

    function automatic op_class_e op_class(input logic [4:0] op);
        op_class_e c;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL: c = CL_ALU;
            OP_MUL, OP_DIV:                  c = CL_MULDIV;
            OP_NEG, OP_NOT:                  c = CL_UNARY;
            OP_NOP:                          c = CL_NOP;
            OP_HALT:                         c = CL_HALT;
            default:                         c = CL_ILLEGAL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/reg_decoder.sv
// 4-bit register index to 16-bit one-hot select, gated by enable.
module reg_decoder (
    input  logic [3:0]  idx,
    input  logic        en,
    output logic [15:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer driving the datapath strobes.
// Moore outputs: decoded from the state register and the live IR.
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] IR,
    input  logic        mem_ready,
    output logic        PC_out,
    output logic        IncPC,
    output logic        PC_enable,
    output logic        MAR_enable,
    output logic        Read,
    output logic        MDR_enable,
    output logic        MDR_out,
    output logic        IR_enable,
    output logic        Y_enable,
    output logic        Z_enable,
    output logic        ZLow_out,
    output logic        ZHigh_out,
    output logic        HI_enable,
    output logic        LO_enable,
    output logic [4:0]  opcode,
    output logic [15:0] R_out,
    output logic [15:0] R_enable,
    output logic        run,
    output logic        illegal
);

    state_e    state_q, state_d;
    logic      illegal_q, illegal_d;
    op_class_e cls;
    logic [4:0] opc;
    logic [3:0] ra, rb, rc;
    logic [3:0] ro_idx, re_idx;
    logic       ro_en, re_en;
    logic       unused_ir;

    assign opc = IR[IR_OP_LSB +: 5];
    assign ra  = IR[IR_RA_LSB +: 4];
    assign rb  = IR[IR_RB_LSB +: 4];
    assign rc  = IR[IR_RC_LSB +: 4];
    assign cls = op_class(opc);
    assign unused_ir = ^IR[14:0];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= ST_RST;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        unique case (state_q)
            ST_RST: state_d = ST_T0;
            ST_T0:  state_d = ST_T1;
            ST_T1:  state_d = mem_ready ? ST_T2 : ST_T1;
            ST_T2:  state_d = ST_T3;
            ST_T3: begin
                case (cls)
                    CL_ALU, CL_MULDIV, CL_UNARY: state_d = ST_T4;
                    CL_HALT:                     state_d = ST_HALT;
                    default:                     state_d = ST_T0;
                endcase
                if (cls == CL_ILLEGAL) illegal_d = 1'b1;
            end
            ST_T4: state_d = (cls == CL_UNARY) ? ST_T0 : ST_T5;
            ST_T5: state_d = (cls == CL_MULDIV) ? ST_T6 : ST_T0;
            ST_T6: state_d = ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    always_comb begin
        PC_out     = 1'b0;
        IncPC      = 1'b0;
        PC_enable  = 1'b0;
        MAR_enable = 1'b0;
        Read       = 1'b0;
        MDR_enable = 1'b0;
        MDR_out    = 1'b0;
        IR_enable  = 1'b0;
        Y_enable   = 1'b0;
        Z_enable   = 1'b0;
        ZLow_out   = 1'b0;
        ZHigh_out  = 1'b0;
        HI_enable  = 1'b0;
        LO_enable  = 1'b0;
        opcode     = 5'd0;
        run        = 1'b1;
        ro_idx     = 4'd0;
        ro_en      = 1'b0;
        re_idx     = 4'd0;
        re_en      = 1'b0;
        unique case (state_q)
            ST_T0: begin
                PC_out     = 1'b1;
                MAR_enable = 1'b1;
                IncPC      = 1'b1;
                PC_enable  = 1'b1;
            end
            ST_T1: begin
                Read       = 1'b1;
                MDR_enable = 1'b1;
            end
            ST_T2: begin
                MDR_out   = 1'b1;
                IR_enable = 1'b1;
            end
            ST_T3: begin
                case (cls)
                    CL_ALU: begin
                        ro_idx = rb; ro_en = 1'b1; Y_enable = 1'b1;
                    end
                    CL_MULDIV: begin
                        ro_idx = ra; ro_en = 1'b1; Y_enable = 1'b1;
                    end
                    CL_UNARY: begin
                        ro_idx = rb; ro_en = 1'b1;
                        opcode = opc; Z_enable = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (cls)
                    CL_ALU: begin
                        ro_idx = rc; ro_en = 1'b1;
                        opcode = opc; Z_enable = 1'b1;
                    end
                    CL_MULDIV: begin
                        ro_idx = rb; ro_en = 1'b1;
                        opcode = opc; Z_enable = 1'b1;
                    end
                    CL_UNARY: begin
                        ZLow_out = 1'b1; re_idx = ra; re_en = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (cls)
                    CL_ALU: begin
                        ZLow_out = 1'b1; re_idx = ra; re_en = 1'b1;
                    end
                    CL_MULDIV: begin
                        ZLow_out = 1'b1; LO_enable = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                ZHigh_out = 1'b1;
                HI_enable = 1'b1;
            end
            ST_HALT: run = 1'b0;
            default: ;
        endcase
    end

    assign illegal = illegal_q;

    reg_decoder u_rout_dec (
        .idx    (ro_idx),
        .en     (ro_en),
        .onehot (R_out)
    );

    reg_decoder u_ren_dec (
        .idx    (re_idx),
        .en     (re_en),
        .onehot (R_enable)
    );

endmodule

// File: tb/tb_control_unit.sv
// Directed table-driven bench for control_unit: per-cycle expected strobes.
// Hand sequences cover mid-instruction reset and the halt state.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clr;
    logic [31:0] IR;
    logic        mem_ready;
    logic        PC_out, IncPC, PC_enable, MAR_enable;
    logic        Read, MDR_enable, MDR_out, IR_enable;
    logic        Y_enable, Z_enable, ZLow_out, ZHigh_out;
    logic        HI_enable, LO_enable, run, illegal;
    logic [4:0]  opcode;
    logic [15:0] R_out, R_enable;

    control_unit dut (
        .clk        (clk),
        .clr        (clr),
        .IR         (IR),
        .mem_ready  (mem_ready),
        .PC_out     (PC_out),
        .IncPC      (IncPC),
        .PC_enable  (PC_enable),
        .MAR_enable (MAR_enable),
        .Read       (Read),
        .MDR_enable (MDR_enable),
        .MDR_out    (MDR_out),
        .IR_enable  (IR_enable),
        .Y_enable   (Y_enable),
        .Z_enable   (Z_enable),
        .ZLow_out   (ZLow_out),
        .ZHigh_out  (ZHigh_out),
        .HI_enable  (HI_enable),
        .LO_enable  (LO_enable),
        .opcode     (opcode),
        .R_out      (R_out),
        .R_enable   (R_enable),
        .run        (run),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // strobe bundle bit masks, MSB first
    localparam logic [15:0] M_T0 = 16'hF000;
    localparam logic [15:0] M_T1 = 16'h0C00;
    localparam logic [15:0] M_T2 = 16'h0300;
    localparam logic [15:0] M_Y  = 16'h0080;
    localparam logic [15:0] M_Z  = 16'h0040;
    localparam logic [15:0] M_ZL = 16'h0020;
    localparam logic [15:0] M_ZH = 16'h0010;
    localparam logic [15:0] M_HI = 16'h0008;
    localparam logic [15:0] M_LO = 16'h0004;
    localparam logic [15:0] M_RUN = 16'h0002;
    localparam logic [15:0] M_ILL = 16'h0001;

    logic [15:0] act_strb;
    assign act_strb = {PC_out, IncPC, PC_enable, MAR_enable,
                       Read, MDR_enable, MDR_out, IR_enable,
                       Y_enable, Z_enable, ZLow_out, ZHigh_out,
                       HI_enable, LO_enable, run, illegal};

    typedef struct {
        logic [31:0] ir;
        logic        mr;
        logic [15:0] strb;
        logic [4:0]  op;
        logic [15:0] ro;
        logic [15:0] re;
        string       nm;
    } vec_t;

    vec_t q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] a,
                                       input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c, 15'd0};
    endfunction

    function automatic void add(input logic [31:0] ir, input logic mr,
                                input logic [15:0] strb, input logic [4:0] op,
                                input logic [15:0] ro, input logic [15:0] re,
                                input string nm);
        vec_t v;
        v.ir = ir; v.mr = mr; v.strb = strb;
        v.op = op; v.ro = ro; v.re = re; v.nm = nm;
        q.push_back(v);
    endfunction

    function automatic void add_fetch(input logic [31:0] ir, input logic [15:0] ill,
                                      input string nm);
        add(ir, 1'b1, M_T0 | M_RUN | ill, 5'd0, 16'h0, 16'h0, {nm, "_T0"});
        add(ir, 1'b1, M_T1 | M_RUN | ill, 5'd0, 16'h0, 16'h0, {nm, "_T1"});
        add(ir, 1'b1, M_T2 | M_RUN | ill, 5'd0, 16'h0, 16'h0, {nm, "_T2"});
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [15:0] strb, input logic [4:0] op,
                           input logic [15:0] ro, input logic [15:0] re);
        chk({nm, ".strb"}, 64'(act_strb), 64'(strb));
        chk({nm, ".opcode"}, 64'(opcode), 64'(op));
        chk({nm, ".R_out"}, 64'(R_out), 64'(ro));
        chk({nm, ".R_enable"}, 64'(R_enable), 64'(re));
    endtask

    task automatic run_q();
        foreach (q[i]) begin
            @(posedge clk);
            #1;
            IR = q[i].ir;
            mem_ready = q[i].mr;
            #1;
            chk_all(q[i].nm, q[i].strb, q[i].op, q[i].ro, q[i].re);
        end
        q.delete();
    endtask

    logic [31:0] ir_and, ir_sub, ir_mul, ir_neg, ir_nop, ir_ill, ir_div, ir_halt;

    initial begin
        ir_and  = 32'h28918000;
        ir_sub  = mk(5'b00100, 4'd7, 4'd0, 4'd15);
        ir_mul  = mk(5'b01111, 4'd4, 4'd5, 4'd0);
        ir_neg  = mk(5'b10001, 4'd9, 4'd6, 4'd0);
        ir_nop  = mk(5'b11010, 4'd1, 4'd2, 4'd3);
        ir_ill  = mk(5'b11111, 4'd1, 4'd2, 4'd3);
        ir_div  = mk(5'b10000, 4'd2, 4'd3, 4'd0);
        ir_halt = mk(5'b11011, 4'd0, 4'd0, 4'd0);

        clr = 1'b0;
        IR = ir_and;
        mem_ready = 1'b1;
        #2;
        chk_all("reset", M_RUN, 5'd0, 16'h0, 16'h0);
        #8;
        clr = 1'b1;

        // and R1,R2,R3
        add_fetch(ir_and, 16'h0, "and");
        add(ir_and, 1, M_RUN | M_Y, 5'd0, 16'h0004, 16'h0, "and_T3");
        add(ir_and, 1, M_RUN | M_Z, 5'b00101, 16'h0008, 16'h0, "and_T4");
        add(ir_and, 1, M_RUN | M_ZL, 5'd0, 16'h0, 16'h0002, "and_T5");
        // sub R7,R0,R15 with three wait cycles in T1
        add(ir_sub, 1, M_T0 | M_RUN, 5'd0, 16'h0, 16'h0, "sub_T0");
        add(ir_sub, 0, M_T1 | M_RUN, 5'd0, 16'h0, 16'h0, "sub_T1w0");
        add(ir_sub, 0, M_T1 | M_RUN, 5'd0, 16'h0, 16'h0, "sub_T1w1");
        add(ir_sub, 0, M_T1 | M_RUN, 5'd0, 16'h0, 16'h0, "sub_T1w2");
        add(ir_sub, 1, M_T1 | M_RUN, 5'd0, 16'h0, 16'h0, "sub_T1go");
        add(ir_sub, 1, M_T2 | M_RUN, 5'd0, 16'h0, 16'h0, "sub_T2");
        add(ir_sub, 1, M_RUN | M_Y, 5'd0, 16'h0001, 16'h0, "sub_T3");
        add(ir_sub, 1, M_RUN | M_Z, 5'b00100, 16'h8000, 16'h0, "sub_T4");
        add(ir_sub, 1, M_RUN | M_ZL, 5'd0, 16'h0, 16'h0080, "sub_T5");
        // mul R4,R5
        add_fetch(ir_mul, 16'h0, "mul");
        add(ir_mul, 1, M_RUN | M_Y, 5'd0, 16'h0010, 16'h0, "mul_T3");
        add(ir_mul, 1, M_RUN | M_Z, 5'b01111, 16'h0020, 16'h0, "mul_T4");
        add(ir_mul, 1, M_RUN | M_ZL | M_LO, 5'd0, 16'h0, 16'h0, "mul_T5");
        add(ir_mul, 1, M_RUN | M_ZH | M_HI, 5'd0, 16'h0, 16'h0, "mul_T6");
        // neg R9,R6
        add_fetch(ir_neg, 16'h0, "neg");
        add(ir_neg, 1, M_RUN | M_Z, 5'b10001, 16'h0040, 16'h0, "neg_T3");
        add(ir_neg, 1, M_RUN | M_ZL, 5'd0, 16'h0, 16'h0200, "neg_T4");
        // nop; IR churn and mem_ready=0 outside T1 must not matter
        add(ir_mul, 0, M_T0 | M_RUN, 5'd0, 16'h0, 16'h0, "nop_T0");
        add(ir_halt, 1, M_T1 | M_RUN, 5'd0, 16'h0, 16'h0, "nop_T1");
        add(ir_ill, 0, M_T2 | M_RUN, 5'd0, 16'h0, 16'h0, "nop_T2");
        add(ir_nop, 1, M_RUN, 5'd0, 16'h0, 16'h0, "nop_T3");
        // illegal opcode 11111
        add_fetch(ir_ill, 16'h0, "ill");
        add(ir_ill, 1, M_RUN, 5'd0, 16'h0, 16'h0, "ill_T3");
        // div R2,R3 with illegal now sticky
        add_fetch(ir_div, M_ILL, "div");
        add(ir_div, 1, M_RUN | M_ILL | M_Y, 5'd0, 16'h0004, 16'h0, "div_T3");
        add(ir_div, 1, M_RUN | M_ILL | M_Z, 5'b10000, 16'h0008, 16'h0, "div_T4");
        run_q();

        // asynchronous reset in the middle of div T4
        #2;
        clr = 1'b0;
        #1;
        chk_all("midreset", M_RUN, 5'd0, 16'h0, 16'h0);
        #2;
        chk_all("midreset_hold", M_RUN, 5'd0, 16'h0, 16'h0);
        #1;
        clr = 1'b1;

        // halt
        add_fetch(ir_halt, 16'h0, "halt");
        add(ir_halt, 1, M_RUN, 5'd0, 16'h0, 16'h0, "halt_T3");
        for (int i = 0; i < 20; i++)
            add(ir_and, (i % 2 == 0), 16'h0, 5'd0, 16'h0, 16'h0, "halt_st");
        run_q();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
